// File: rtl/bridge_defs.sv
// Shared definitions for the data SRAM to AXI bridge.
// Holds the 3-bit FSM state encodings and the fixed AXI field values
// used by the bridge.
package bridge_defs;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_AR   = 3'd1;
    localparam logic [2:0] ST_RD_R    = 3'd2;
    localparam logic [2:0] ST_WR_AW_W = 3'd3;
    localparam logic [2:0] ST_WR_B    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [2:0] AXI_SIZE_WORD = 3'b010;
    localparam logic [1:0] RESP_OKAY     = 2'b00;

endpackage

// File: rtl/data_sram_axi_bridge.sv
// data_sram_axi_bridge
// Turns each access accepted on the core's data SRAM-like port into one
// single-beat AXI4 read or write, stalling the pipeline until it completes
// and holding the read data stable for the memory stage afterwards.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   data_sram_en/we/addr/wdata  core request (we == 0 means read)
//   data_sram_rdata             last read data, held until the next read
//   stallreq                    pipeline stall request
//   ar*/r*                      AXI read address / read data channels
//   aw*/w*/b*                   AXI write address / data / response channels
//   bus_err                     one-cycle pulse on a non-OKAY response
module data_sram_axi_bridge
    import bridge_defs::*;
#(
    parameter logic [3:0] AXI_ID  = 4'd1,
    parameter int         DATA_WD = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 data_sram_en,
    input  logic [3:0]           data_sram_we,
    input  logic [DATA_WD-1:0]   data_sram_addr,
    input  logic [DATA_WD-1:0]   data_sram_wdata,
    output logic [DATA_WD-1:0]   data_sram_rdata,
    output logic                 stallreq,
    output logic                 arvalid,
    input  logic                 arready,
    output logic [DATA_WD-1:0]   araddr,
    output logic [3:0]           arid,
    output logic [2:0]           arsize,
    input  logic                 rvalid,
    output logic                 rready,
    input  logic [DATA_WD-1:0]   rdata,
    input  logic [1:0]           rresp,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [DATA_WD-1:0]   awaddr,
    output logic [3:0]           awid,
    output logic [2:0]           awsize,
    output logic                 wvalid,
    input  logic                 wready,
    output logic [DATA_WD-1:0]   wdata,
    output logic [3:0]           wstrb,
    output logic                 wlast,
    input  logic                 bvalid,
    output logic                 bready,
    input  logic [1:0]           bresp,
    output logic                 bus_err
);

    logic [2:0]         state;
    logic [DATA_WD-1:2] addr_q;     // word address; byte offset is always dropped
    logic [DATA_WD-1:0] wdata_q;
    logic [3:0]         we_q;
    logic [DATA_WD-1:0] rdata_q;
    logic               aw_done;
    logic               w_done;
    logic               bus_err_q;
    logic               aw_fin;
    logic               w_fin;

    // A channel is finished once it has handshaken now or earlier in WR_AW_W.
    assign aw_fin = aw_done || (awvalid && awready);
    assign w_fin  = w_done  || (wvalid  && wready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= '0;
            rdata_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (data_sram_en) begin
                        addr_q  <= data_sram_addr[DATA_WD-1:2];
                        wdata_q <= data_sram_wdata;
                        we_q    <= data_sram_we;
                        state   <= (data_sram_we == 4'b0000) ? ST_RD_AR : ST_WR_AW_W;
                    end
                end
                ST_RD_AR: begin
                    if (arready) state <= ST_RD_R;
                end
                ST_RD_R: begin
                    if (rvalid) begin
                        rdata_q   <= rdata;
                        bus_err_q <= (rresp != RESP_OKAY);
                        state     <= ST_DONE;
                    end
                end
                ST_WR_AW_W: begin
                    if (awvalid && awready) aw_done <= 1'b1;
                    if (wvalid && wready)   w_done  <= 1'b1;
                    // Flags are cleared on the way out so the next write starts clean.
                    if (aw_fin && w_fin) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (bvalid) begin
                        bus_err_q <= (bresp != RESP_OKAY);
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // In IDLE the request cycle itself stalls; gating with resetn keeps the
    // stall low while reset is held even if the core still presents en.
    always_comb begin
        stallreq = 1'b0;
        if (state == ST_IDLE) stallreq = data_sram_en && resetn;
        else if (state != ST_DONE) stallreq = 1'b1;
    end

    assign data_sram_rdata = rdata_q;
    assign bus_err         = bus_err_q;

    assign arvalid = (state == ST_RD_AR);
    assign araddr  = {addr_q, 2'b00};
    assign arid    = AXI_ID;
    assign arsize  = AXI_SIZE_WORD;
    assign rready  = (state == ST_RD_R);

    assign awvalid = (state == ST_WR_AW_W) && !aw_done;
    assign awaddr  = {addr_q, 2'b00};
    assign awid    = AXI_ID;
    assign awsize  = AXI_SIZE_WORD;
    assign wvalid  = (state == ST_WR_AW_W) && !w_done;
    assign wdata   = wdata_q;
    assign wstrb   = we_q;
    assign wlast   = 1'b1;
    assign bready  = (state == ST_WR_B);

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Self-checking bench for data_sram_axi_bridge: a delay-programmable AXI
// slave, a transaction-level model of the bridge checked every cycle, and
// directed accesses with hand-computed expectations.
module tb_data_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] araddr, rdata;
    logic [3:0]  arid, awid, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready, bus_err;
    logic [31:0] awaddr, wdata;

    int vectors = 0;
    int miscompares = 0;

    // slave programming
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] rdata_val = '0;
    logic [1:0]  rresp_val = '0, bresp_val = '0;

    // observation counters
    int stall_cnt = 0, arv_cnt = 0, awv_cnt = 0, wv_cnt = 0, berr_cnt = 0, ar_total = 0;

    always #5 clk = ~clk;

    data_sram_axi_bridge #(.AXI_ID(4'd1), .DATA_WD(32)) dut (
        .clk(clk), .resetn(resetn),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .stallreq(stallreq),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arsize(arsize),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awsize(awsize),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bus_err(bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an access is either absent, in flight, or in
    // its one-cycle completion slot. Channel progress is tracked by observed
    // handshakes only.
    localparam int P_IDLE = 0, P_BUSY = 1, P_DONE = 2;
    int          m_phase = P_IDLE;
    bit          m_rd, m_ar_hs, m_aw_hs, m_w_hs, m_berr;
    logic [31:0] m_addr, m_wdata, m_rdata = '0;
    logic [3:0]  m_we;
    bit          r_pend, b_pend;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;

    initial begin
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        forever begin
            bit hs_ar, hs_r, hs_aw, hs_w, hs_b, busy_rd, busy_wr;
            @(negedge clk);
            if (!resetn) begin
                m_phase = P_IDLE; m_rdata = '0; m_berr = 0;
                m_ar_hs = 0; m_aw_hs = 0; m_w_hs = 0;
                r_pend = 0; b_pend = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end

            // compare current cycle
            busy_rd = (m_phase == P_BUSY) && m_rd;
            busy_wr = (m_phase == P_BUSY) && !m_rd;
            check("stallreq", stallreq, (m_phase == P_IDLE) ? {31'd0, data_sram_en & resetn}
                                                          : {31'd0, m_phase == P_BUSY});
            check("rdata_hold", data_sram_rdata, m_rdata);
            check("bus_err", bus_err, (m_phase == P_DONE) ? {31'd0, m_berr} : 32'd0);
            check("arvalid", arvalid, {31'd0, busy_rd && !m_ar_hs});
            check("rready", rready, {31'd0, busy_rd && m_ar_hs});
            check("awvalid", awvalid, {31'd0, busy_wr && !m_aw_hs});
            check("wvalid", wvalid, {31'd0, busy_wr && !m_w_hs});
            check("bready", bready, {31'd0, busy_wr && m_aw_hs && m_w_hs});
            check("wlast", wlast, 32'd1);
            if (arvalid) begin
                check("araddr", araddr, m_addr);
                check("arid", arid, 32'd1);
                check("arsize", arsize, 32'd2);
            end
            if (awvalid) begin
                check("awaddr", awaddr, m_addr);
                check("awid", awid, 32'd1);
                check("awsize", awsize, 32'd2);
            end
            if (wvalid) begin
                check("wdata", wdata, m_wdata);
                check("wstrb", wstrb, m_we);
            end
            if (stallreq) stall_cnt++;
            if (arvalid)  arv_cnt++;
            if (awvalid)  awv_cnt++;
            if (wvalid)   wv_cnt++;
            if (bus_err)  berr_cnt++;

            // slave drive
            if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin arready = 0; ar_cnt = 0; end
            if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
            if (r_pend) begin rvalid = (r_cnt >= r_dly); r_cnt++; end
            else begin rvalid = 0; r_cnt = 0; end
            if (b_pend) begin bvalid = (b_cnt >= b_dly); b_cnt++; end
            else begin bvalid = 0; b_cnt = 0; end
            rdata = rvalid ? rdata_val : 32'h0;
            rresp = rvalid ? rresp_val : 2'b00;
            bresp = bvalid ? bresp_val : 2'b00;

            // handshakes at the coming edge, advance model
            hs_ar = arvalid && arready;
            hs_r  = rvalid && rready;
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_b  = bvalid && bready;
            if (hs_ar) begin ar_total++; r_pend = 1; end
            if (hs_r)  r_pend = 0;
            if (hs_b)  b_pend = 0;

            case (m_phase)
                P_IDLE: if (data_sram_en && resetn) begin
                    m_phase = P_BUSY;
                    m_rd    = (data_sram_we == 4'b0000);
                    m_addr  = {data_sram_addr[31:2], 2'b00};
                    m_wdata = data_sram_wdata;
                    m_we    = data_sram_we;
                    m_ar_hs = 0; m_aw_hs = 0; m_w_hs = 0; m_berr = 0;
                end
                P_BUSY: begin
                    if (hs_ar) m_ar_hs = 1;
                    if (hs_aw) m_aw_hs = 1;
                    if (hs_w)  m_w_hs  = 1;
                    if (!m_rd && m_aw_hs && m_w_hs && !hs_b && !bready) b_pend = 1;
                    if (hs_r) begin
                        m_rdata = rdata_val; m_berr = (rresp_val != 2'b00); m_phase = P_DONE;
                    end
                    if (hs_b) begin
                        m_berr = (bresp_val != 2'b00); m_phase = P_DONE;
                    end
                end
                default: begin m_phase = P_IDLE; m_berr = 0; end
            endcase
        end
    end

    // Present a request and hold it until the completion cycle (en stays high
    // there, as the core would); returns #1 into the completion cycle.
    task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        bit done = 0;
        data_sram_en = 1; data_sram_we = w; data_sram_addr = a; data_sram_wdata = d;
        for (int n = 0; n < 60 && !done; n++) begin
            @(posedge clk); #1;
            if (!stallreq) done = 1;
        end
        check("access_completes", {31'd0, done}, 32'd1);
    endtask

    task automatic idle(input int n);
        data_sram_en = 0; data_sram_we = '0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int n0;
        resetn = 0; data_sram_en = 0; data_sram_we = '0; data_sram_addr = '0; data_sram_wdata = '0;
        repeat (3) @(posedge clk);
        #3 resetn = 1;
        @(posedge clk); #1;
        check("reset_rdata", data_sram_rdata, 32'h0);
        check("reset_stall", stallreq, 32'h0);

        // read, zero-wait slave
        rdata_val = 32'hDEADBEEF;
        stall_cnt = 0; arv_cnt = 0;
        access(4'b0000, 32'h1C000104, 32'h0);
        check("rd0_stall_cycles", stall_cnt, 32'd3);
        check("rd0_arvalid_cycles", arv_cnt, 32'd1);
        check("rd0_rdata", data_sram_rdata, 32'hDEADBEEF);
        idle(2);
        check("rd0_rdata_held", data_sram_rdata, 32'hDEADBEEF);

        // read, arready delayed 3 cycles, unaligned address
        ar_dly = 3; rdata_val = 32'hCAFEF00D;
        stall_cnt = 0; arv_cnt = 0;
        access(4'b0000, 32'h1C000107, 32'h0);
        check("rd1_stall_cycles", stall_cnt, 32'd6);
        check("rd1_arvalid_cycles", arv_cnt, 32'd4);
        check("rd1_rdata", data_sram_rdata, 32'hCAFEF00D);
        idle(1);
        ar_dly = 0;

        // write, AW accepted first, W three cycles later
        w_dly = 3;
        stall_cnt = 0; awv_cnt = 0; wv_cnt = 0;
        access(4'b0011, 32'h1C000200, 32'h12345678);
        check("wr0_stall_cycles", stall_cnt, 32'd6);
        check("wr0_awvalid_cycles", awv_cnt, 32'd1);
        check("wr0_wvalid_cycles", wv_cnt, 32'd4);
        check("wr0_rdata_unchanged", data_sram_rdata, 32'hCAFEF00D);
        idle(1);
        w_dly = 0;

        // write, simultaneous AW/W, SLVERR response
        bresp_val = 2'b10; berr_cnt = 0; stall_cnt = 0;
        access(4'b1111, 32'h1C000300, 32'hA5A5A5A5);
        check("wr1_stall_cycles", stall_cnt, 32'd3);
        check("wr1_bus_err_now", bus_err, 32'd1);
        idle(3);
        check("wr1_bus_err_pulses", berr_cnt, 32'd1);
        bresp_val = 2'b00;

        // en held through the completion cycle is ignored
        n0 = ar_total; rdata_val = 32'h11112222;
        access(4'b0000, 32'h1C000400, 32'h0);
        idle(3);
        check("done_en_ignored", ar_total - n0, 32'd1);
        // back-to-back: a new request right after completion starts afresh
        access(4'b0000, 32'h1C000408, 32'h0);
        rdata_val = 32'h33334444;
        access(4'b0000, 32'h1C00040C, 32'h0);
        idle(1);
        check("b2b_ar_count", ar_total - n0, 32'd3);
        check("b2b_rdata", data_sram_rdata, 32'h33334444);

        // reset while waiting for read data
        r_dly = 10;
        data_sram_en = 1; data_sram_we = 4'b0000; data_sram_addr = 32'h1C000600;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_rready_before", rready, 32'd1);
        #2 resetn = 0;
        #1;
        check("rst_rready_async", rready, 32'd0);
        check("rst_arvalid_async", arvalid, 32'd0);
        check("rst_stall_async", stallreq, 32'd0);
        check("rst_rdata_async", data_sram_rdata, 32'd0);
        data_sram_en = 0;
        @(posedge clk); @(posedge clk);
        #3 resetn = 1;
        idle(2);
        check("rst_idle_stall", stallreq, 32'd0);
        r_dly = 0; rdata_val = 32'h55AA55AA; stall_cnt = 0;
        access(4'b0000, 32'h1C000700, 32'h0);
        check("post_rst_stall_cycles", stall_cnt, 32'd3);
        check("post_rst_rdata", data_sram_rdata, 32'h55AA55AA);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
